// File: rtl/mem_pwr_seq.sv
// rtl/mem_pwr_seq.sv - power-state sequencer for the memory controller
module mem_pwr_seq #(
    parameter int IDLE_CYC = 16,
    parameter int PULSE_W  = 2,
    parameter int ACK_TMO  = 64
) (
    input  logic clk,
    input  logic rst,
    input  logic auto_en,
    input  logic sleep_req,
    input  logic wake_req,
    input  logic do_rdy,
    input  logic do_acpt,
    input  logic mc_pwr_ack,
    output logic do_rdy_g,
    output logic mc_pwr,
    output logic mc_iso,
    output logic mc_save,
    output logic mc_restore,
    output logic pwr_on,
    output logic pwr_err
);

    typedef enum logic [2:0] {
        ST_ON    = 3'd0,
        ST_ISO   = 3'd1,
        ST_SAVE  = 3'd2,
        ST_PDN   = 3'd3,
        ST_OFF   = 3'd4,
        ST_PUP   = 3'd5,
        ST_RST   = 3'd6,
        ST_UNISO = 3'd7
    } state_t;

    localparam logic [7:0] IDLE_MIN   = 8'd8;
    localparam logic [7:0] IDLE_THR   = 8'(IDLE_CYC);
    localparam logic [9:0] PULSE_LAST = 10'(PULSE_W - 1);
    localparam logic [9:0] TMO_LAST   = 10'(ACK_TMO - 1);

    state_t     state_q, state_d;
    logic [7:0] idle_cnt_q, idle_cnt_d;
    logic [7:0] idle_nxt;
    logic [9:0] cnt_q, cnt_d;
    logic       timeout;
    logic       mc_pwr_q, mc_pwr_d;
    logic       mc_iso_q, mc_iso_d;
    logic       mc_save_q, mc_save_d;
    logic       mc_restore_q, mc_restore_d;
    logic       pwr_on_q, pwr_on_d;
    logic       pwr_err_q, pwr_err_d;

    // Next state, shared counter and output decode from the next state
    always_comb begin
        state_d   = state_q;
        pwr_err_d = pwr_err_q;
        // idle_nxt is the quiet-cycle count including the current cycle
        idle_nxt  = 8'd0;
        if (!(do_rdy || do_acpt)) begin
            idle_nxt = (idle_cnt_q == 8'hff) ? 8'hff : idle_cnt_q + 8'd1;
        end
        timeout = (cnt_q == TMO_LAST);

        case (state_q)
            ST_ON: begin
                // Floor of 8 quiet cycles lets the controller finish its post-accept tail
                if (!do_rdy && (idle_nxt >= IDLE_MIN) &&
                    (sleep_req || (auto_en && (idle_nxt >= IDLE_THR)))) begin
                    state_d = ST_ISO;
                end
            end
            ST_ISO:  state_d = ST_SAVE;
            ST_SAVE: begin
                if (cnt_q == PULSE_LAST) state_d = ST_PDN;
            end
            ST_PDN: begin
                if (!mc_pwr_ack) begin
                    state_d = ST_OFF;
                end else if (timeout) begin
                    state_d   = ST_OFF;
                    pwr_err_d = 1'b1;
                end
            end
            ST_OFF: begin
                if (!sleep_req && (wake_req || do_rdy)) state_d = ST_PUP;
            end
            ST_PUP: begin
                if (mc_pwr_ack) begin
                    state_d = ST_RST;
                end else if (timeout) begin
                    state_d   = ST_RST;
                    pwr_err_d = 1'b1;
                end
            end
            ST_RST: begin
                if (cnt_q == PULSE_LAST) state_d = ST_UNISO;
            end
            ST_UNISO: state_d = ST_ON;
            default:  state_d = ST_ON;
        endcase

        // Pulse width and ack timeout share one counter, restarted on every state change
        if (state_d != state_q) begin
            cnt_d = 10'd0;
        end else begin
            cnt_d = (cnt_q == 10'h3ff) ? cnt_q : cnt_q + 10'd1;
        end

        idle_cnt_d   = ((state_q == ST_ON) && (state_d == ST_ON)) ? idle_nxt : 8'd0;
        mc_pwr_d     = !((state_d == ST_PDN) || (state_d == ST_OFF));
        mc_iso_d     = (state_d != ST_ON);
        mc_save_d    = (state_d == ST_SAVE);
        mc_restore_d = (state_d == ST_RST);
        pwr_on_d     = (state_d == ST_ON);
    end

    // State, counters and registered outputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= ST_ON;
            idle_cnt_q   <= 8'd0;
            cnt_q        <= 10'd0;
            mc_pwr_q     <= 1'b1;
            mc_iso_q     <= 1'b0;
            mc_save_q    <= 1'b0;
            mc_restore_q <= 1'b0;
            pwr_on_q     <= 1'b1;
            pwr_err_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            idle_cnt_q   <= idle_cnt_d;
            cnt_q        <= cnt_d;
            mc_pwr_q     <= mc_pwr_d;
            mc_iso_q     <= mc_iso_d;
            mc_save_q    <= mc_save_d;
            mc_restore_q <= mc_restore_d;
            pwr_on_q     <= pwr_on_d;
            pwr_err_q    <= pwr_err_d;
        end
    end

    assign do_rdy_g   = do_rdy && (state_q == ST_ON);
    assign mc_pwr     = mc_pwr_q;
    assign mc_iso     = mc_iso_q;
    assign mc_save    = mc_save_q;
    assign mc_restore = mc_restore_q;
    assign pwr_on     = pwr_on_q;
    assign pwr_err    = pwr_err_q;

endmodule

// File: tb/tb_mem_pwr_seq.sv
// tb/tb_mem_pwr_seq.sv - self-checking bench for mem_pwr_seq
module tb_mem_pwr_seq;

    localparam int IDLE_CYC = 16;
    localparam int PULSE_W  = 2;
    localparam int ACK_TMO  = 64;

    logic clk       = 1'b0;
    logic rst       = 1'b1;
    logic auto_en   = 1'b1;
    logic sleep_req = 1'b0;
    logic wake_req  = 1'b0;
    logic do_rdy    = 1'b0;
    logic do_acpt   = 1'b0;
    logic mc_pwr_ack;
    logic do_rdy_g, mc_pwr, mc_iso, mc_save, mc_restore, pwr_on, pwr_err;

    int n_checks = 0;
    int n_fail   = 0;

    // Power switch: ack follows mc_pwr with a delay of ack_sel+1 edges, or is tied
    logic [7:0] ack_hist    = 8'hff;
    logic [2:0] ack_sel     = 3'd2;
    logic       ack_tie_en  = 1'b0;
    logic       ack_tie_val = 1'b0;
    assign mc_pwr_ack = ack_tie_en ? ack_tie_val : ack_hist[ack_sel];

    always @(negedge clk) ack_hist <= {ack_hist[6:0], mc_pwr};

    always #5 clk = ~clk;

    mem_pwr_seq #(.IDLE_CYC(IDLE_CYC), .PULSE_W(PULSE_W), .ACK_TMO(ACK_TMO)) dut (
        .clk(clk), .rst(rst), .auto_en(auto_en), .sleep_req(sleep_req),
        .wake_req(wake_req), .do_rdy(do_rdy), .do_acpt(do_acpt),
        .mc_pwr_ack(mc_pwr_ack), .do_rdy_g(do_rdy_g), .mc_pwr(mc_pwr),
        .mc_iso(mc_iso), .mc_save(mc_save), .mc_restore(mc_restore),
        .pwr_on(pwr_on), .pwr_err(pwr_err)
    );

    task automatic chk1(input string name, input logic act, input logic exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
        end
    endtask

    task automatic chki(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: a procedural timeline of one sleep/wake round trip
    logic exp_pwr, exp_iso, exp_save, exp_rest, exp_on, exp_err;
    bit   ab;

    task automatic set_exp(input logic p, input logic i, input logic s, input logic r, input logic o);
        exp_pwr = p; exp_iso = i; exp_save = s; exp_rest = r; exp_on = o;
    endtask

    task automatic wait_edge();
        @(posedge clk or posedge rst);
        if (rst) ab = 1'b1;
    endtask

    task automatic model_seq();
        int idle;
        int n;
        forever begin
            set_exp(1, 0, 0, 0, 1);
            idle = 0;
            forever begin
                wait_edge(); if (ab) return;
                if (do_rdy || do_acpt) idle = 0;
                else if (idle < 255) idle++;
                if (!do_rdy && idle >= 8 && (sleep_req || (auto_en && idle >= IDLE_CYC))) break;
            end
            set_exp(1, 1, 0, 0, 0);
            wait_edge(); if (ab) return;
            set_exp(1, 1, 1, 0, 0);
            repeat (PULSE_W - 1) begin wait_edge(); if (ab) return; end
            wait_edge(); if (ab) return;
            set_exp(0, 1, 0, 0, 0);
            n = 0;
            forever begin
                wait_edge(); if (ab) return;
                n++;
                if (!mc_pwr_ack) break;
                if (n >= ACK_TMO) begin exp_err = 1'b1; break; end
            end
            forever begin
                wait_edge(); if (ab) return;
                if (!sleep_req && (wake_req || do_rdy)) break;
            end
            set_exp(1, 1, 0, 0, 0);
            n = 0;
            forever begin
                wait_edge(); if (ab) return;
                n++;
                if (mc_pwr_ack) break;
                if (n >= ACK_TMO) begin exp_err = 1'b1; break; end
            end
            set_exp(1, 1, 0, 1, 0);
            repeat (PULSE_W - 1) begin wait_edge(); if (ab) return; end
            wait_edge(); if (ab) return;
            set_exp(1, 1, 0, 0, 0);
            wait_edge(); if (ab) return;
        end
    endtask

    initial begin
        forever begin
            set_exp(1, 0, 0, 0, 1);
            exp_err = 1'b0;
            wait (rst == 1'b0);
            ab = 1'b0;
            model_seq();
        end
    end

    // Every-cycle comparison against the model
    always @(posedge clk) begin
        #1;
        chk1("mc_pwr", mc_pwr, exp_pwr);
        chk1("mc_iso", mc_iso, exp_iso);
        chk1("mc_save", mc_save, exp_save);
        chk1("mc_restore", mc_restore, exp_rest);
        chk1("pwr_on", pwr_on, exp_on);
        chk1("pwr_err", pwr_err, exp_err);
        chk1("do_rdy_g", do_rdy_g, do_rdy & exp_on);
    end

    logic [7:0] pw_r, on_r, rs_r, g_r;

    initial begin
        int k_hit;
        int cnt;
        bit seen;

        // Reset values
        @(posedge clk); #1;
        chk1("rst_pwr", mc_pwr, 1'b1);
        chk1("rst_iso", mc_iso, 1'b0);
        chk1("rst_on", pwr_on, 1'b1);
        chk1("rst_err", pwr_err, 1'b0);

        // Auto-sleep with ack delay 3
        @(negedge clk); rst = 1'b0;
        for (int e = 1; e <= 19; e++) begin
            @(posedge clk); #1;
            if (e == 15) chk1("auto_iso15", mc_iso, 1'b0);
            if (e == 16) chk1("auto_iso16", mc_iso, 1'b1);
            if (e == 16) chk1("auto_save16", mc_save, 1'b0);
            if (e == 17) chk1("auto_save17", mc_save, 1'b1);
            if (e == 18) chk1("auto_save18", mc_save, 1'b1);
            if (e == 18) chk1("auto_pwr18", mc_pwr, 1'b1);
            if (e == 19) chk1("auto_save19", mc_save, 1'b0);
            if (e == 19) chk1("auto_pwr19", mc_pwr, 1'b0);
        end
        repeat (8) @(negedge clk);

        // Wake on traffic with ack delay 2
        ack_sel = 3'd1;
        do_rdy  = 1'b1;
        for (int c = 0; c < 8; c++) begin
            @(posedge clk); #1;
            pw_r[c] = mc_pwr; on_r[c] = pwr_on; rs_r[c] = mc_restore; g_r[c] = do_rdy_g;
        end
        chk1("wake_pwr0", pw_r[0], 1'b1);
        chk1("wake_rs1", rs_r[1], 1'b0);
        chk1("wake_rs2", rs_r[2], 1'b1);
        chk1("wake_rs3", rs_r[3], 1'b1);
        chk1("wake_rs4", rs_r[4], 1'b0);
        chk1("wake_on4", on_r[4], 1'b0);
        chk1("wake_on5", on_r[5], 1'b1);
        chk1("wake_g4", g_r[4], 1'b0);
        chk1("wake_g5", g_r[5], 1'b1);

        // Drain: sleep_req with two accept cycles
        @(negedge clk);
        do_rdy = 1'b0; auto_en = 1'b0; sleep_req = 1'b1; do_acpt = 1'b1;
        @(negedge clk);
        @(negedge clk); do_acpt = 1'b0;
        k_hit = -1;
        for (int k = 1; k <= 12; k++) begin
            @(posedge clk); #1;
            if (k_hit < 0 && mc_iso) k_hit = k;
        end
        chki("drain_iso_delay", k_hit, 8);
        repeat (15) @(negedge clk);

        // Priority: sleep_req holds the block off
        wake_req = 1'b1; do_rdy = 1'b1;
        cnt = 0;
        for (int k = 0; k < 20; k++) begin
            @(posedge clk); #1;
            if (mc_pwr) cnt++;
        end
        chki("prio_pwr_cycles", cnt, 0);
        @(negedge clk); sleep_req = 1'b0;
        repeat (12) @(negedge clk);
        chk1("prio_wake_on", pwr_on, 1'b1);
        do_rdy = 1'b0; wake_req = 1'b0;

        // Ack timeout in PDN
        ack_tie_en = 1'b1; ack_tie_val = 1'b1; sleep_req = 1'b1;
        seen = 1'b0;
        for (int k = 0; k < 60 && !seen; k++) begin
            @(posedge clk); #1;
            if (!mc_pwr) seen = 1'b1;
        end
        chk1("tmo_pdn_seen", seen, 1'b1);
        k_hit = -1;
        for (int k = 1; k <= 80; k++) begin
            @(posedge clk); #1;
            if (k_hit < 0 && pwr_err) k_hit = k;
        end
        chki("tmo_err_delay", k_hit, 64);
        @(negedge clk); sleep_req = 1'b0; wake_req = 1'b1;
        repeat (10) @(negedge clk);
        wake_req = 1'b0;
        chk1("tmo_wake_on", pwr_on, 1'b1);
        chk1("tmo_err_sticky", pwr_err, 1'b1);
        ack_tie_en = 1'b0;
        repeat (4) @(negedge clk);

        // Async reset while saving
        sleep_req = 1'b1;
        seen = 1'b0;
        for (int k = 0; k < 40 && !seen; k++) begin
            @(posedge clk); #1;
            if (mc_save) seen = 1'b1;
        end
        chk1("ar_save_seen", seen, 1'b1);
        #2 rst = 1'b1;
        #1;
        chk1("ar_save", mc_save, 1'b0);
        chk1("ar_pwr", mc_pwr, 1'b1);
        chk1("ar_iso", mc_iso, 1'b0);
        chk1("ar_on", pwr_on, 1'b1);
        chk1("ar_err", pwr_err, 1'b0);
        @(negedge clk); rst = 1'b0; sleep_req = 1'b0;

        // Randomized traffic, sleep/wake requests, ack delays and resets
        for (int i = 0; i < 4000; i++) begin
            @(negedge clk);
            if ($urandom_range(0, 31) == 0) sleep_req = ~sleep_req;
            if ($urandom_range(0, 127) == 0) auto_en = ~auto_en;
            wake_req = ($urandom_range(0, 15) == 0);
            if (do_rdy) do_rdy = ($urandom_range(0, 3) != 0);
            else        do_rdy = ($urandom_range(0, 23) == 0);
            do_acpt = do_rdy ? 1'($urandom_range(0, 1)) : ($urandom_range(0, 19) == 0);
            if (i % 64 == 0) ack_sel = 3'($urandom_range(0, 5));
            if (i % 700 == 350) begin ack_tie_en = 1'b1; ack_tie_val = 1'($urandom_range(0, 1)); end
            if (i % 700 == 500) ack_tie_en = 1'b0;
            if ($urandom_range(0, 499) == 0) begin
                #3 rst = 1'b1;
                @(negedge clk); rst = 1'b0;
            end
        end
        @(negedge clk);
        sleep_req = 1'b0; wake_req = 1'b0; do_rdy = 1'b0; do_acpt = 1'b0;
        repeat (4) @(negedge clk);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
